// File: rtl/deframer.sv
// Splits a framed stream into payload beats plus a marker-checked width/height footer.
// Payload is forwarded through a single-entry output register; footer beats are consumed here.
module deframer #(
    parameter int                     PackedWidth    = 8,
    parameter int                     PacketLenElems = 1024,
    parameter logic [PackedWidth-1:0] TailByte0      = 8'hA5,
    parameter logic [PackedWidth-1:0] TailByte1      = 8'h5A,
    localparam int                    DimensionWidth = 2 * PackedWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [PackedWidth-1:0]    data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [PackedWidth-1:0]    payload_o,
    output logic                      last_o,
    output logic [DimensionWidth-1:0] image_width_o,
    output logic [DimensionWidth-1:0] image_height_o,
    output logic                      dims_valid_o,
    output logic                      frame_error_o
);

    // A one-beat packet still needs a 1-bit counter to keep the vector legal.
    localparam int                  CntWidth = (PacketLenElems > 1) ? $clog2(PacketLenElems) : 1;
    localparam logic [CntWidth-1:0] LastCnt  = CntWidth'(PacketLenElems - 1);

    typedef enum logic [2:0] {
        ST_PAYLOAD  = 3'd0,
        ST_TAIL0    = 3'd1,
        ST_TAIL1    = 3'd2,
        ST_WIDTH_H  = 3'd3,
        ST_WIDTH_L  = 3'd4,
        ST_HEIGHT_H = 3'd5,
        ST_HEIGHT_L = 3'd6
    } state_t;

    state_t                    state_r;
    logic [CntWidth-1:0]       cnt_r;
    logic [DimensionWidth-1:0] width_sh_r;
    logic [DimensionWidth-1:0] height_sh_r;
    logic                      in_fire_s;

    assign in_fire_s = valid_i && ready_o;

    // Input acceptance: payload needs room in the output register, footer beats are always taken.
    always_comb begin
        ready_o = 1'b1;
        if (state_r == ST_PAYLOAD) begin
            ready_o = !valid_o || ready_i;
        end else begin
            ready_o = 1'b1;
        end
    end

    // Framing state machine together with its registered outputs and dimension capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r        <= ST_PAYLOAD;
            cnt_r          <= '0;
            width_sh_r     <= '0;
            height_sh_r    <= '0;
            valid_o        <= 1'b0;
            last_o         <= 1'b0;
            payload_o      <= '0;
            image_width_o  <= '0;
            image_height_o <= '0;
            dims_valid_o   <= 1'b0;
            frame_error_o  <= 1'b0;
        end else begin
            dims_valid_o  <= 1'b0;
            frame_error_o <= 1'b0;

            // Drain the output register; a payload accept below overrides this.
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end

            if (in_fire_s) begin
                case (state_r)
                    ST_PAYLOAD: begin
                        payload_o <= data_i;
                        valid_o   <= 1'b1;
                        if (cnt_r == LastCnt) begin
                            last_o  <= 1'b1;
                            cnt_r   <= '0;
                            state_r <= ST_TAIL0;
                        end else begin
                            last_o  <= 1'b0;
                            cnt_r   <= cnt_r + CntWidth'(1);
                        end
                    end
                    ST_TAIL0: begin
                        if (data_i == TailByte0) begin
                            state_r <= ST_TAIL1;
                        end else begin
                            frame_error_o <= 1'b1;
                            state_r       <= ST_PAYLOAD;
                        end
                    end
                    ST_TAIL1: begin
                        if (data_i == TailByte1) begin
                            state_r <= ST_WIDTH_H;
                        end else begin
                            frame_error_o <= 1'b1;
                            state_r       <= ST_PAYLOAD;
                        end
                    end
                    ST_WIDTH_H: begin
                        width_sh_r[DimensionWidth-1:PackedWidth] <= data_i;
                        state_r <= ST_WIDTH_L;
                    end
                    ST_WIDTH_L: begin
                        width_sh_r[PackedWidth-1:0] <= data_i;
                        state_r <= ST_HEIGHT_H;
                    end
                    ST_HEIGHT_H: begin
                        height_sh_r[DimensionWidth-1:PackedWidth] <= data_i;
                        state_r <= ST_HEIGHT_L;
                    end
                    ST_HEIGHT_L: begin
                        // Low height byte arrives on this beat, so publish it directly.
                        height_sh_r[PackedWidth-1:0] <= data_i;
                        image_width_o  <= width_sh_r;
                        image_height_o <= {height_sh_r[DimensionWidth-1:PackedWidth], data_i};
                        dims_valid_o   <= 1'b1;
                        state_r        <= ST_PAYLOAD;
                    end
                    default: begin
                        state_r <= ST_PAYLOAD;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deframer.sv
// Directed bench for deframer with 4-beat packets of 8-bit beats.
module tb_deframer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  data_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  payload_o;
    logic        last_o;
    logic [15:0] image_width_o;
    logic [15:0] image_height_o;
    logic        dims_valid_o;
    logic        frame_error_o;

    logic        stall_en = 1'b0;
    logic        tog_r    = 1'b0;
    int          checks   = 0;
    int          errors   = 0;

    logic [7:0]  pay_q[$];
    logic        last_q[$];
    int          dims_cnt  = 0;
    int          ferr_cnt  = 0;
    int          stab_viol = 0;
    int          rdy_viol  = 0;
    logic [15:0] cap_w     = 16'h0000;
    logic [15:0] cap_h     = 16'h0000;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_pay   = 8'h00;
    logic        prev_last  = 1'b0;

    deframer #(
        .PackedWidth   (8),
        .PacketLenElems(4),
        .TailByte0     (8'hA5),
        .TailByte1     (8'h5A)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_i        (data_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .payload_o     (payload_o),
        .last_o        (last_o),
        .image_width_o (image_width_o),
        .image_height_o(image_height_o),
        .dims_valid_o  (dims_valid_o),
        .frame_error_o (frame_error_o)
    );

    always #5 clk_i = ~clk_i;

    assign ready_i = stall_en ? tog_r : 1'b1;

    // Alternating downstream ready, changed just after each rising edge.
    always @(posedge clk_i) begin
        #1;
        tog_r = ~tog_r;
    end

    // Output monitor on the falling edge: records transfers, pulses and handshake rules.
    always @(negedge clk_i) begin
        if (prev_stall && !(valid_o && payload_o === prev_pay && last_o === prev_last))
            stab_viol++;
        if (!ready_o && !(valid_o && !ready_i))
            rdy_viol++;
        if (valid_o && ready_i) begin
            pay_q.push_back(payload_o);
            last_q.push_back(last_o);
        end
        if (dims_valid_o) begin
            dims_cnt++;
            cap_w = image_width_o;
            cap_h = image_height_o;
        end
        if (frame_error_o)
            ferr_cnt++;
        prev_stall = valid_o && !ready_i;
        prev_pay   = payload_o;
        prev_last  = last_o;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Presents one beat and returns just after the edge that accepted it.
    task automatic send(input logic [7:0] d, output int waited);
        logic acc;
        waited  = 0;
        valid_i = 1'b1;
        data_i  = d;
        do begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            waited++;
        end while (!acc && waited < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat %h not accepted within %0d cycles (required accept)", d, waited);
        end
    endtask

    task automatic send_seq(input logic [7:0] s[10], output int total);
        int w;
        total = 0;
        for (int i = 0; i < 10; i++) begin
            send(s[i], w);
            total += w;
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        idle(2);
        checks++;
        if ({valid_o, last_o, dims_valid_o, frame_error_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {valid_o, last_o, dims_valid_o, frame_error_o});
        end
        checks++;
        if (payload_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_payload: got %h required 00", payload_o);
        end
        checks++;
        if (image_width_o !== 16'h0000 || image_height_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dims: got %h/%h required 0000/0000", image_width_o, image_height_o);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", ready_o);
        end
        rst_i = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        logic [7:0] s[10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'h01, 8'h40, 8'h00, 8'hF0};
        int w;
        int d0 = dims_cnt;
        for (int i = 0; i < 10; i++) begin
            send(s[i], w);
            if (i < 4) begin
                checks++;
                if (valid_o !== 1'b1 || payload_o !== s[i] || last_o !== (i == 3)) begin
                    errors++;
                    $display("FAIL basic_latency[%0d]: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                             i, valid_o, payload_o, last_o, s[i], (i == 3));
                end
            end
        end
        valid_i = 1'b0;
        checks++;
        if (dims_valid_o !== 1'b1 || image_width_o !== 16'h0140 || image_height_o !== 16'h00F0) begin
            errors++;
            $display("FAIL basic_dims: got p=%b w=%h h=%h required p=1 w=0140 h=00f0",
                     dims_valid_o, image_width_o, image_height_o);
        end
        idle(1);
        checks++;
        if (dims_valid_o !== 1'b0 || dims_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_pulse: got p=%b count=%0d required p=0 count=1", dims_valid_o, dims_cnt - d0);
        end
    endtask

    task automatic test_stall();
        logic [7:0] s[10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'h01, 8'h40, 8'h00, 8'hF0};
        int tot;
        int base = pay_q.size();
        int d0   = dims_cnt;
        stall_en = 1'b1;
        send_seq(s, tot);
        valid_i = 1'b0;
        idle(6);
        stall_en = 1'b0;
        idle(1);
        checks++;
        if (pay_q.size() - base !== 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats required 4", pay_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pay_q[base+i] !== s[i] || last_q[base+i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL stall_beat[%0d]: got %h/%b required %h/%b",
                             i, pay_q[base+i], last_q[base+i], s[i], (i == 3));
                end
            end
        end
        checks++;
        if (stab_viol !== 0 || rdy_viol !== 0) begin
            errors++;
            $display("FAIL stall_handshake: got stability=%0d ready=%0d violations required 0/0", stab_viol, rdy_viol);
        end
        checks++;
        if (dims_cnt - d0 !== 1 || cap_w !== 16'h0140 || cap_h !== 16'h00F0) begin
            errors++;
            $display("FAIL stall_dims: got n=%0d w=%h h=%h required n=1 w=0140 h=00f0", dims_cnt - d0, cap_w, cap_h);
        end
    endtask

    task automatic test_bad_footer();
        logic [7:0] a[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h77};
        logic [7:0] s[10] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h02};
        int w;
        int d0 = dims_cnt;
        int f0 = ferr_cnt;
        int base;
        for (int i = 0; i < 6; i++) send(a[i], w);
        valid_i = 1'b0;
        idle(2);
        checks++;
        if (ferr_cnt - f0 !== 1 || dims_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL badfoot_pulses: got err=%0d dims=%0d required err=1 dims=0", ferr_cnt - f0, dims_cnt - d0);
        end
        checks++;
        if (image_width_o !== 16'h0140 || image_height_o !== 16'h00F0) begin
            errors++;
            $display("FAIL badfoot_keep: got %h/%h required 0140/00f0", image_width_o, image_height_o);
        end
        base = pay_q.size();
        send_seq(s, w);
        valid_i = 1'b0;
        idle(2);
        checks++;
        if (pay_q.size() - base !== 4) begin
            errors++;
            $display("FAIL badfoot_count: got %0d beats required 4", pay_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pay_q[base+i] !== s[i] || last_q[base+i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL badfoot_beat[%0d]: got %h/%b required %h/%b",
                             i, pay_q[base+i], last_q[base+i], s[i], (i == 3));
                end
            end
        end
        checks++;
        if (image_width_o !== 16'h0001 || image_height_o !== 16'h0002 || ferr_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL badfoot_recover: got %h/%h err=%0d required 0001/0002 err=1",
                     image_width_o, image_height_o, ferr_cnt - f0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s1[10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'h02, 8'h80, 8'h01, 8'hE0};
        logic [7:0] s2[10] = '{8'h05, 8'h06, 8'h07, 8'h08, 8'hA5, 8'h5A, 8'h03, 8'h20, 8'h02, 8'h58};
        int t1, t2;
        int base = pay_q.size();
        int d0   = dims_cnt;
        int lasts = 0;
        send_seq(s1, t1);
        send_seq(s2, t2);
        valid_i = 1'b0;
        idle(2);
        checks++;
        if (t1 + t2 !== 20) begin
            errors++;
            $display("FAIL b2b_cycles: got %0d input cycles required 20", t1 + t2);
        end
        checks++;
        if (pay_q.size() - base !== 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats required 8", pay_q.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                lasts += last_q[base+i] ? 1 : 0;
                checks++;
                if (pay_q[base+i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL b2b_beat[%0d]: got %h required %h", i, pay_q[base+i], 8'(i + 1));
                end
            end
            checks++;
            if (lasts !== 2 || last_q[base+3] !== 1'b1 || last_q[base+7] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_last: got %0d lasts required 2 on beats 3 and 7", lasts);
            end
        end
        checks++;
        if (dims_cnt - d0 !== 2 || cap_w !== 16'h0320 || cap_h !== 16'h0258) begin
            errors++;
            $display("FAIL b2b_dims: got n=%0d w=%h h=%h required n=2 w=0320 h=0258", dims_cnt - d0, cap_w, cap_h);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] s[10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'h00, 8'h08, 8'h00, 8'h06};
        int w;
        int base;
        send(8'h11, w);
        send(8'h22, w);
        valid_i = 1'b0;
        #3;
        rst_i = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || payload_o !== 8'h00 || last_o !== 1'b0 || image_width_o !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h l=%b w=%h required 0/00/0/0000",
                     valid_o, payload_o, last_o, image_width_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        base = pay_q.size();
        send_seq(s, w);
        valid_i = 1'b0;
        idle(2);
        checks++;
        if (pay_q.size() - base !== 4) begin
            errors++;
            $display("FAIL areset_count: got %0d beats required 4", pay_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pay_q[base+i] !== s[i] || last_q[base+i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL areset_beat[%0d]: got %h/%b required %h/%b",
                             i, pay_q[base+i], last_q[base+i], s[i], (i == 3));
                end
            end
        end
        checks++;
        if (image_width_o !== 16'h0008 || image_height_o !== 16'h0006) begin
            errors++;
            $display("FAIL areset_dims: got %h/%h required 0008/0006", image_width_o, image_height_o);
        end
    endtask

    task automatic test_marker_payload();
        logic [7:0] s[10] = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'hA5, 8'h5A, 8'h00, 8'h10, 8'h00, 8'h20};
        int w;
        int base = pay_q.size();
        int f0   = ferr_cnt;
        int d0   = dims_cnt;
        send_seq(s, w);
        valid_i = 1'b0;
        idle(2);
        checks++;
        if (pay_q.size() - base !== 4) begin
            errors++;
            $display("FAIL marker_count: got %0d beats required 4", pay_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pay_q[base+i] !== s[i] || last_q[base+i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL marker_beat[%0d]: got %h/%b required %h/%b",
                             i, pay_q[base+i], last_q[base+i], s[i], (i == 3));
                end
            end
        end
        checks++;
        if (ferr_cnt - f0 !== 0 || dims_cnt - d0 !== 1 || cap_w !== 16'h0010 || cap_h !== 16'h0020) begin
            errors++;
            $display("FAIL marker_dims: got err=%0d n=%0d w=%h h=%h required 0/1/0010/0020",
                     ferr_cnt - f0, dims_cnt - d0, cap_w, cap_h);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_bad_footer();
        test_back_to_back();
        test_async_reset();
        test_marker_payload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
